mem_wb_pipe: RTL and testbench

Parametrised, multi-lane successor to the single-issue MEM→WB pipeline register. It registers up to `LANES` memory-stage results per cycle and computes per-lane data-TLB exceptions. Results younger than the first faulting lane are suppressed for precise commit. A valid/ready handshake with a one-group skid buffer replaces the old stall-freeze behaviour. It sits between the memory stage and the writeback/commit stage.

---
 rtl/mem_wb_pipe.sv | 162 ++++++++++++++++
 tb/tb_mem_wb_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - multi-lane MEM->WB pipeline register with DTLB exceptions, precise kill and skid buffer
module mem_wb_pipe #(
   parameter int LANES  = 2,
   parameter int DATA_W = 32,
   parameter int EXCP_W = 10
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic [1:0]                         csr_plv,
   input  logic [LANES-1:0]                   in_valid,
   output logic                               in_ready,
   input  logic [LANES*32-1:0]                in_pc,
   input  logic [LANES-1:0]                   in_wreg,
   input  logic [LANES-1:0]                   in_is_load,
   input  logic [LANES-1:0]                   in_is_store,
   input  logic [LANES*5-1:0]                 in_waddr,
   input  logic [LANES*DATA_W-1:0]            in_wdata,
   input  logic [LANES-1:0]                   in_excp,
   input  logic [LANES*EXCP_W-1:0]            in_excp_num,
   input  logic [LANES-1:0]                   tlb_trans_en,
   input  logic [LANES-1:0]                   tlb_found,
   input  logic [LANES-1:0]                   tlb_v,
   input  logic [LANES-1:0]                   tlb_d,
   input  logic [LANES*2-1:0]                 tlb_plv,
   output logic [LANES-1:0]                   out_valid,
   input  logic                               out_ready,
   output logic [LANES*32-1:0]                out_pc,
   output logic [LANES-1:0]                   out_we,
   output logic [LANES*5-1:0]                 out_waddr,
   output logic [LANES*DATA_W-1:0]            out_wdata,
   output logic [LANES-1:0]                   out_excp,
   output logic [LANES*(EXCP_W+5)-1:0]        out_excp_num,
   output logic [$clog2(LANES+1)-1:0]         out_commit_cnt
);

   localparam int EN      = EXCP_W + 5;
   localparam int CW      = $clog2(LANES + 1);
   // A whole group is carried as one packed vector; fields laid out from bit 0 upward.
   localparam int OFF_VLD = 0;
   localparam int OFF_PC  = OFF_VLD + LANES;
   localparam int OFF_WE  = OFF_PC + LANES * 32;
   localparam int OFF_WA  = OFF_WE + LANES;
   localparam int OFF_WD  = OFF_WA + LANES * 5;
   localparam int OFF_EX  = OFF_WD + LANES * DATA_W;
   localparam int OFF_EN  = OFF_EX + LANES;
   localparam int GW      = OFF_EN + LANES * EN;

   logic [GW-1:0]           o_q, o_d, s_q, s_d, proc_grp;
   logic                    s_full_q, s_full_d, pend_q, pend_d;
   logic [LANES-1:0]        p_valid, p_we, p_excp;
   logic [LANES*EN-1:0]     p_enum;
   logic                    acc, tlbr, pil, pis, ppi, pme, lx, seen, any_excp;
   logic                    out_fire, in_fire, take, o_empty;
   logic [CW-1:0]           cnt;

   // Per-lane DTLB checks and precise kill: only lanes up to the first faulting one survive.
   always_comb begin
      p_valid  = '0;
      p_we     = '0;
      p_excp   = '0;
      p_enum   = '0;
      acc      = 1'b0;
      tlbr     = 1'b0;
      pil      = 1'b0;
      pis      = 1'b0;
      ppi      = 1'b0;
      pme      = 1'b0;
      lx       = 1'b0;
      seen     = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         acc  = in_is_load[i] | in_is_store[i];
         tlbr = acc & ~tlb_found[i] & tlb_trans_en[i];
         pil  = in_is_load[i] & ~tlb_v[i] & tlb_trans_en[i];
         pis  = in_is_store[i] & ~tlb_v[i] & tlb_trans_en[i];
         ppi  = acc & tlb_v[i] & (csr_plv > tlb_plv[i*2 +: 2]) & tlb_trans_en[i];
         pme  = in_is_store[i] & tlb_v[i] & (csr_plv <= tlb_plv[i*2 +: 2])
                & ~tlb_d[i] & tlb_trans_en[i];
         lx   = in_valid[i] & (tlbr | pil | pis | ppi | pme | in_excp[i]);
         p_enum[i*EN +: EN] = {pil, pis, ppi, pme, tlbr, in_excp_num[i*EXCP_W +: EXCP_W]};
         if (!seen) begin
            p_valid[i] = in_valid[i];
            p_excp[i]  = lx;
            p_we[i]    = in_valid[i] & in_wreg[i] & ~lx;
            seen       = lx;
         end
      end
      any_excp = seen;
   end

   assign proc_grp = {p_enum, p_excp, in_wdata, in_waddr, p_we, in_pc, p_valid};

   assign o_empty  = ~|o_q[OFF_VLD +: LANES];
   assign out_fire = ~o_empty & out_ready;
   assign in_fire  = ~s_full_q & |in_valid;
   assign take     = in_fire & ~pend_q;

   // Output/skid register update: S drains into O first, fenced groups are swallowed.
   always_comb begin
      o_d      = o_q;
      s_d      = s_q;
      s_full_d = s_full_q;
      pend_d   = pend_q;
      if (flush) begin
         o_d      = '0;
         s_d      = '0;
         s_full_d = 1'b0;
         pend_d   = 1'b0;
      end else begin
         if (take && any_excp) begin
            pend_d = 1'b1;
         end
         if (o_empty || out_fire) begin
            if (s_full_q) begin
               o_d      = s_q;
               s_full_d = 1'b0;
            end else if (take) begin
               o_d = proc_grp;
            end else begin
               o_d = '0;
            end
         end else if (take) begin
            s_d      = proc_grp;
            s_full_d = 1'b1;
         end
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_q      <= '0;
         s_q      <= '0;
         s_full_q <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         o_q      <= o_d;
         s_q      <= s_d;
         s_full_q <= s_full_d;
         pend_q   <= pend_d;
      end
   end

   // Count lanes that retire without an exception.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         cnt = cnt + CW'(o_q[OFF_VLD + i] & ~o_q[OFF_EX + i]);
      end
   end

   assign in_ready       = ~s_full_q;
   assign out_valid      = o_q[OFF_VLD +: LANES];
   assign out_pc         = o_q[OFF_PC  +: LANES * 32];
   assign out_we         = o_q[OFF_WE  +: LANES];
   assign out_waddr      = o_q[OFF_WA  +: LANES * 5];
   assign out_wdata      = o_q[OFF_WD  +: LANES * DATA_W];
   assign out_excp       = o_q[OFF_EX  +: LANES];
   assign out_excp_num   = o_q[OFF_EN  +: LANES * EN];
   assign out_commit_cnt = cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - directed table-driven bench for mem_wb_pipe
module tb_mem_wb_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [1:0]  csr_plv;
   logic [1:0]  in_valid, in_wreg, in_is_load, in_is_store, in_excp;
   logic [1:0]  tlb_trans_en, tlb_found, tlb_v, tlb_d;
   logic [3:0]  tlb_plv;
   logic        in_ready, out_ready;
   logic [63:0] in_pc, in_wdata;
   logic [9:0]  in_waddr;
   logic [19:0] in_excp_num;
   logic [1:0]  out_valid, out_we, out_excp, out_commit_cnt;
   logic [63:0] out_pc, out_wdata;
   logic [9:0]  out_waddr;
   logic [29:0] out_excp_num;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_wb_pipe #(.LANES(2), .DATA_W(32), .EXCP_W(10)) dut (
      .clk(clk), .rst(rst_n), .flush(flush), .csr_plv(csr_plv),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_wreg(in_wreg),
      .in_is_load(in_is_load), .in_is_store(in_is_store), .in_waddr(in_waddr),
      .in_wdata(in_wdata), .in_excp(in_excp), .in_excp_num(in_excp_num),
      .tlb_trans_en(tlb_trans_en), .tlb_found(tlb_found), .tlb_v(tlb_v), .tlb_d(tlb_d),
      .tlb_plv(tlb_plv), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_we(out_we), .out_waddr(out_waddr), .out_wdata(out_wdata), .out_excp(out_excp),
      .out_excp_num(out_excp_num), .out_commit_cnt(out_commit_cnt)
   );

   typedef struct {
      logic [1:0]  valid, wreg, ld, st, excp, trans, found, v, d, cplv;
      logic [63:0] pc, wdata;
      logic [9:0]  waddr;
      logic [19:0] enum_in;
      logic [3:0]  tplv;
      logic [1:0]  e_valid, e_we, e_excp, e_cnt;
      logic [29:0] e_enum;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = '0; in_wreg = '0; in_is_load = '0; in_is_store = '0; in_excp = '0;
      tlb_trans_en = '0; tlb_found = '0; tlb_v = '0; tlb_d = '0; tlb_plv = '0;
      csr_plv = '0; in_pc = '0; in_wdata = '0; in_waddr = '0; in_excp_num = '0;
   endtask

   task automatic offer(input int tag);
      idle();
      in_valid = 2'b11;
      in_wreg  = 2'b11;
      in_pc    = {32'h1c000004 + 32'(tag), 32'h1c000000 + 32'(tag)};
      in_wdata = {32'(tag) + 32'd1, 32'(tag)};
      in_waddr = {5'd3, 5'd4};
   endtask

   task automatic apply(input vec_t x);
      in_valid = x.valid; in_wreg = x.wreg; in_is_load = x.ld; in_is_store = x.st;
      in_excp = x.excp; tlb_trans_en = x.trans; tlb_found = x.found; tlb_v = x.v;
      tlb_d = x.d; tlb_plv = x.tplv; csr_plv = x.cplv; in_pc = x.pc;
      in_wdata = x.wdata; in_waddr = x.waddr; in_excp_num = x.enum_in;
   endtask

   function automatic vec_t base();
      vec_t v;
      v.valid = 2'b11; v.wreg = 2'b11; v.ld = '0; v.st = '0; v.excp = '0;
      v.trans = '0; v.found = '0; v.v = '0; v.d = '0; v.cplv = '0; v.tplv = '0;
      v.pc = {32'h1c000004, 32'h1c000000}; v.wdata = {32'h22, 32'h11};
      v.waddr = {5'd2, 5'd1}; v.enum_in = '0;
      v.e_valid = 2'b11; v.e_we = 2'b11; v.e_excp = '0; v.e_cnt = 2'd2; v.e_enum = '0;
      return v;
   endfunction

   task automatic check_vec(input int i, input vec_t x);
      logic [29:0] em;
      logic [63:0] wm;
      logic [9:0]  am;
      em = {{15{x.e_valid[1]}}, {15{x.e_valid[0]}}};
      wm = {{32{x.e_valid[1]}}, {32{x.e_valid[0]}}};
      am = {{5{x.e_valid[1]}}, {5{x.e_valid[0]}}};
      chk($sformatf("v%0d_valid", i), out_valid, x.e_valid);
      chk($sformatf("v%0d_we", i), out_we, x.e_we);
      chk($sformatf("v%0d_excp", i), out_excp, x.e_excp);
      chk($sformatf("v%0d_excp_num", i), out_excp_num & em, x.e_enum & em);
      chk($sformatf("v%0d_cnt", i), out_commit_cnt, x.e_cnt);
      chk($sformatf("v%0d_pc", i), out_pc & wm, x.pc & wm);
      chk($sformatf("v%0d_wdata", i), out_wdata & wm, x.wdata & wm);
      chk($sformatf("v%0d_waddr", i), out_waddr & am, x.waddr & am);
   endtask

   initial begin
      vec_t v;
      // basic two-lane commit
      v = base(); vecs.push_back(v);
      // lane0 store, clean page with plv 0/0 -> pme, lane1 killed
      v = base(); v.st = 2'b01; v.trans = 2'b01; v.found = 2'b01; v.v = 2'b01;
      v.e_valid = 2'b01; v.e_we = 2'b00; v.e_excp = 2'b01; v.e_cnt = 2'd0;
      v.e_enum = {15'h0, 15'h0800}; vecs.push_back(v);
      // lane1 load misses TLB -> tlbr, lane0 commits
      v = base(); v.ld = 2'b10; v.trans = 2'b10; v.found = 2'b00; v.v = 2'b10;
      v.e_we = 2'b01; v.e_excp = 2'b10; v.e_cnt = 2'd1;
      v.e_enum = {15'h0400, 15'h0}; vecs.push_back(v);
      // lane0 load at plv3 on plv0 page -> ppi
      v = base(); v.ld = 2'b01; v.trans = 2'b01; v.found = 2'b01; v.v = 2'b01;
      v.cplv = 2'd3; v.tplv = 4'h0;
      v.e_valid = 2'b01; v.e_we = 2'b00; v.e_excp = 2'b01; v.e_cnt = 2'd0;
      v.e_enum = {15'h0, 15'h1000}; vecs.push_back(v);
      // lane1 store to invalid page -> pis
      v = base(); v.st = 2'b10; v.trans = 2'b10; v.found = 2'b10; v.v = 2'b00;
      v.e_we = 2'b01; v.e_excp = 2'b10; v.e_cnt = 2'd1;
      v.e_enum = {15'h2000, 15'h0}; vecs.push_back(v);
      // lane0 invalid (its would-be tlbr ignored), lane1 upstream exception
      v = base(); v.valid = 2'b10; v.ld = 2'b01; v.trans = 2'b01; v.found = 2'b00;
      v.excp = 2'b10; v.enum_in = {10'h155, 10'h0};
      v.e_valid = 2'b10; v.e_we = 2'b00; v.e_excp = 2'b10; v.e_cnt = 2'd0;
      v.e_enum = {15'h0155, 15'h0}; vecs.push_back(v);
      // translation disabled: no exceptions despite miss
      v = base(); v.st = 2'b01; vecs.push_back(v);
      // lane0 store plv1 on plv2 clean page -> pme, lane1 killed
      v = base(); v.st = 2'b11; v.trans = 2'b11; v.found = 2'b11; v.v = 2'b11;
      v.d = 2'b10; v.cplv = 2'd1; v.tplv = {2'd1, 2'd2};
      v.e_valid = 2'b01; v.e_we = 2'b00; v.e_excp = 2'b01; v.e_cnt = 2'd0;
      v.e_enum = {15'h0, 15'h0800}; vecs.push_back(v);
      // same, both pages dirty and plv equal/lower -> no exception
      v = base(); v.st = 2'b11; v.trans = 2'b11; v.found = 2'b11; v.v = 2'b11;
      v.d = 2'b11; v.cplv = 2'd1; v.tplv = {2'd1, 2'd2}; vecs.push_back(v);
      // lane0 load to invalid page -> pil
      v = base(); v.ld = 2'b01; v.trans = 2'b01; v.found = 2'b01; v.v = 2'b00;
      v.e_valid = 2'b01; v.e_we = 2'b00; v.e_excp = 2'b01; v.e_cnt = 2'd0;
      v.e_enum = {15'h0, 15'h4000}; vecs.push_back(v);

      idle();
      flush = 1'b0;
      out_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("reset_out_valid", out_valid, 2'b00);
      chk("reset_wdata", out_wdata, 64'h0);
      chk("reset_cnt", out_commit_cnt, 2'd0);
      chk("reset_in_ready", in_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("post_reset_in_ready", in_ready, 1'b1);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
         step();
         check_vec(i, vecs[i]);
         idle();
         flush = 1'b1;
         step();
         flush = 1'b0;
         chk($sformatf("v%0d_flush_valid", i), out_valid, 2'b00);
         chk($sformatf("v%0d_flush_ready", i), in_ready, 1'b1);
      end

      // exception fence: later groups dropped until flush
      apply(vecs[1]);
      step();
      chk("fence_excp", out_excp, 2'b01);
      apply(vecs[0]);
      step();
      chk("fence_drop1", out_valid, 2'b00);
      chk("fence_ready", in_ready, 1'b1);
      step();
      chk("fence_drop2", out_valid, 2'b00);
      idle(); flush = 1'b1; step(); flush = 1'b0;
      apply(vecs[0]);
      step();
      chk("fence_clear_valid", out_valid, 2'b11);
      chk("fence_clear_cnt", out_commit_cnt, 2'd2);
      idle(); step();

      // backpressure: three offers while stalled, only two taken, order kept
      out_ready = 1'b0;
      offer(32'hA0); step();
      chk("bp1_data", out_wdata, {32'hA1, 32'hA0});
      chk("bp1_ready", in_ready, 1'b1);
      offer(32'hB0); step();
      chk("bp2_data", out_wdata, {32'hA1, 32'hA0});
      chk("bp2_ready", in_ready, 1'b0);
      offer(32'hC0); step();
      chk("bp3_data", out_wdata, {32'hA1, 32'hA0});
      chk("bp3_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      step();
      chk("bp4_data", out_wdata, {32'hB1, 32'hB0});
      chk("bp4_ready", in_ready, 1'b1);
      step();
      chk("bp5_data", out_wdata, {32'hC1, 32'hC0});
      chk("bp5_valid", out_valid, 2'b11);
      idle(); step();
      chk("bp6_empty", out_valid, 2'b00);

      // full throughput
      for (int k = 0; k < 4; k++) begin
         offer(k * 16 + 1);
         step();
         chk($sformatf("tp%0d_data", k), out_wdata, {32'(k * 16 + 2), 32'(k * 16 + 1)});
         chk($sformatf("tp%0d_pc", k), out_pc, {32'h1c000005 + 32'(k * 16), 32'h1c000001 + 32'(k * 16)});
      end
      idle(); step();

      // flush with O and S full drops everything including the offered group
      out_ready = 1'b0;
      offer(32'h10); step();
      offer(32'h20); step();
      chk("fl_s_full", in_ready, 1'b0);
      offer(32'h30); flush = 1'b1; step(); flush = 1'b0;
      idle();
      chk("fl_valid", out_valid, 2'b00);
      chk("fl_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      offer(32'h50); flush = 1'b1; step(); flush = 1'b0;
      idle();
      chk("fl_drop_offer", out_valid, 2'b00);
      offer(32'h40); step();
      chk("fl_after_data", out_wdata, {32'h41, 32'h40});
      chk("fl_after_valid", out_valid, 2'b11);
      idle(); step();

      // asynchronous reset between edges
      out_ready = 1'b0;
      offer(32'h60); step();
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 2'b00);
      chk("arst_wdata", out_wdata, 64'h0);
      chk("arst_pc", out_pc, 64'h0);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      offer(32'h70); step();
      chk("arst_after_valid", out_valid, 2'b11);
      chk("arst_after_data", out_wdata, {32'h71, 32'h70});
      idle(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
